sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single 128-bit AES key/data SRAM between two requesters: the AHB host-side interface (key/data load, result readback) and the AES core (round-key and state traffic).
- Serialises requests with round-robin arbitration and issues exactly one SRAM read or write strobe per granted access.
- Captures read data and returns it to the requester that issued the read.
- Supports a core burst lock for back-to-back round-key accesses, bounded by a maximum length.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 128, SRAM word width
LOCK_MAX, 11, max consecutive core grants under c_lock before host is serviced

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
h_req  in  1  host access request; held with h_we/h_addr/h_wdata until h_gnt
h_we  in  1  host: 1=write, 0=read
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  one-cycle pulse: host access issued this cycle
h_rvalid  out  1  one-cycle pulse: rdata holds host read result
c_req  in  1  core access request; same hold rule as h_req
c_we  in  1  core: 1=write, 0=read
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_lock  in  1  core requests burst priority
c_gnt  out  1  one-cycle pulse: core access issued this cycle
c_rvalid  out  1  one-cycle pulse: rdata holds core read result
rdata  out  DATA_W  captured SRAM read data (shared by both requesters)
lock_abort  out  1  one-cycle pulse when the LOCK_MAX limit forces a host grant
read  out  1  SRAM read strobe
write  out  1  SRAM write strobe
addr  out  ADDR_W  SRAM address
write_data  out  DATA_W  SRAM write data
read_data  in  DATA_W  SRAM read data, valid while read is high

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; last_winner=core (host wins the first tie); lock_cnt=0.
- FSM, two states:
  - IDLE: if no req, stay. Otherwise select a winner, register winner's we/addr/wdata into addr/write_data, and go to ACCESS.
  - ACCESS: read=~we or write=we, all registered. Winner's gnt=1. Always go to IDLE next.
  - Only one of read/write is ever high. Both are 0 in IDLE.
- Throughput: one access per 2 cycles. gnt high in ACCESS tells the requester its fields are consumed; it may drop req or present new fields during ACCESS. req is never sampled in ACCESS, so there is no double grant.
- Read return: at the ACCESS->IDLE edge, rdata<=read_data. The issuing requester's rvalid pulses in the following IDLE cycle, 2 cycles after the arbitration edge. rdata holds until the next read capture. Writes produce no rvalid.
- Arbitration in IDLE:
  - Single req: that requester wins.
  - Both req: the requester that is not last_winner wins, unless the lock override applies.
  - Lock override: c_lock=1, last_winner=core and lock_cnt<LOCK_MAX → core wins.
- lock_cnt:
  - Increments on each core grant made while c_lock=1.
  - Clears on any host grant, or on any IDLE cycle with c_lock=0.
  - Saturates at LOCK_MAX.
- Lock limit: if lock_cnt==LOCK_MAX and h_req=1 → host wins and lock_abort pulses in that ACCESS cycle. If h_req=0, the core continues to be granted.
- Address and data are passed unmodified; no range checks.
- Reset mid-ACCESS: strobes, gnt and rvalid drop immediately. The access is lost and the requester must re-request after reset.
- Changing fields while req is high and gnt is not yet seen: the fields sampled at the arbitration edge are used.

Test Plan:
- Host write, h_addr=0, h_wdata=128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516 → in the cycle after the request: write=1, addr=0, write_data equals h_wdata, h_gnt=1; read=0.
- Host write, h_addr=32, h_wdata=128'hAAF43DDD_A22100EF_8766450A_B4321176; then host read at 32 → read=1 with addr=32; next cycle h_rvalid=1 with rdata equal to the written value; c_rvalid=0.
- h_req and c_req held high continuously, no lock → grants alternate host, core, host, core, one per 2 cycles.
- c_lock=1 with both requesting → 11 consecutive c_gnt; the 12th grant goes to the host with lock_abort=1. Repeat with h_req=0: core granted indefinitely, lock_abort never pulses.
- Core read at addr 5 while a host write is pending (host last winner) → core issued first, c_rvalid with the SRAM word at 5, then the host write is issued.
- Assert rst during ACCESS of a write → write, c_gnt and h_gnt go to 0 immediately. After release, a held h_req is granted (last_winner reset to core).

Source files
------------

// File: rtl/sram_access_arbiter_if.sv
// Signal bundle between the two SRAM requesters (AHB host, AES core), the
// arbiter and the shared key/data SRAM.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128
);
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_lock;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              lock_abort;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    // Requester and SRAM side of the bundle.
    modport master (
        output h_req, h_we, h_addr, h_wdata,
        output c_req, c_we, c_addr, c_wdata, c_lock,
        output read_data,
        input  h_gnt, h_rvalid, c_gnt, c_rvalid, rdata, lock_abort,
        input  read, write, addr, write_data
    );

    modport slave (
        input  h_req, h_we, h_addr, h_wdata,
        input  c_req, c_we, c_addr, c_wdata, c_lock,
        input  read_data,
        output h_gnt, h_rvalid, c_gnt, c_rvalid, rdata, lock_abort,
        output read, write, addr, write_data
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing the single AES key/data SRAM between the AHB host
// port and the AES core, with a bounded core burst lock.
module sram_access_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 128,
    parameter int LOCK_MAX = 11
) (
    input logic                  clk,
    input logic                  rst,
    sram_access_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nxt;
    logic              last_core;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              grant, pick_core, abort_nxt, sel_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              read_q, write_q, h_gnt_q, c_gnt_q;
    logic              h_rvalid_q, c_rvalid_q, abort_q;

    // Winner selection and burst-lock bookkeeping; requests are only looked at in IDLE.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        grant        = 1'b0;
        pick_core    = 1'b0;
        abort_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.c_lock) lock_cnt_nxt = '0;
                if (bus.h_req || bus.c_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    if (bus.h_req && bus.c_req) begin
                        if (bus.c_lock && lock_cnt == CNT_MAX) begin
                            abort_nxt = 1'b1;
                        end else if (bus.c_lock && last_core) begin
                            pick_core = 1'b1;
                        end else begin
                            pick_core = !last_core;
                        end
                    end else begin
                        pick_core = bus.c_req;
                    end
                    if (!pick_core) begin
                        lock_cnt_nxt = '0;
                    end else if (bus.c_lock && lock_cnt != CNT_MAX) begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_we = pick_core ? bus.c_we : bus.h_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_core <= 1'b1;
            lock_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (grant) last_core <= pick_core;
        end
    end

    // Strobes and grants live for exactly the ACCESS cycle; read data is
    // captured as ACCESS ends and flagged to whoever issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            h_gnt_q    <= 1'b0;
            c_gnt_q    <= 1'b0;
            abort_q    <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
        end else begin
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            h_gnt_q    <= 1'b0;
            c_gnt_q    <= 1'b0;
            abort_q    <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
            if (grant) begin
                addr_q  <= pick_core ? bus.c_addr : bus.h_addr;
                wdata_q <= pick_core ? bus.c_wdata : bus.h_wdata;
                read_q  <= !sel_we;
                write_q <= sel_we;
                h_gnt_q <= !pick_core;
                c_gnt_q <= pick_core;
                abort_q <= abort_nxt;
            end
            if (state == ACCESS && read_q) begin
                rdata_q    <= bus.read_data;
                h_rvalid_q <= h_gnt_q;
                c_rvalid_q <= c_gnt_q;
            end
        end
    end

    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.h_gnt      = h_gnt_q;
    assign bus.c_gnt      = c_gnt_q;
    assign bus.lock_abort = abort_q;
    assign bus.h_rvalid   = h_rvalid_q;
    assign bus.c_rvalid   = c_rvalid_q;
    assign bus.rdata      = rdata_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a transaction-level model predicts
// each SRAM access and read return; a monitor checks them as the DUT emits them.
module tb_sram_access_arbiter;
    localparam int LOCK_MAX = 11;

    typedef struct {
        int unsigned  cyc;
        logic         core;
        logic         we;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic         abort;
    } acc_t;

    typedef struct {
        int unsigned  cyc;
        logic         core;
        logic [127:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int compared = 0;
    int mismatched = 0;

    acc_t exp_q[$];
    rd_t  rd_q[$];

    logic [127:0] sram      [64];
    logic [127:0] model_mem [64];
    logic         m_busy, m_last_core;
    int           m_cnt;

    int c_gnt_total = 0;
    int abort_count = 0;
    int abort_at    = 0;

    sram_access_arbiter_if #(.ADDR_W(16), .DATA_W(128)) bus();

    sram_access_arbiter #(.ADDR_W(16), .DATA_W(128), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] init_word(input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9E3779B1 ^ 32'hA5A5_0000;
        return {w, ~w, w ^ 32'h1234_5678, 32'(i)};
    endfunction

    // SRAM behaviour: combinational read while read is high, write on the clock.
    assign bus.read_data = bus.read ? sram[bus.addr[5:0]] : '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
        end else if (bus.write) begin
            sram[bus.addr[5:0]] <= bus.write_data;
        end
    end

    task automatic check_output(input string name, input logic [191:0] act, input logic [191:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request at a negedge and hold it until the grant is seen.
    task automatic apply_stimulus(input bit core, input bit we, input logic [15:0] a,
                                  input logic [127:0] d, input bit lk);
        bit seen;
        seen = 1'b0;
        if (core) begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d; bus.c_lock = lk;
        end else begin
            bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
        end
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = core ? bus.c_gnt : bus.h_gnt;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL gnt_timeout: core=%0d got no grant, expected one within 200 cycles", core);
        end
        if (core) begin
            bus.c_req = 1'b0; bus.c_lock = 1'b0;
        end else begin
            bus.h_req = 1'b0;
        end
    endtask

    // Reference model: one access per two cycles, winner from the arbitration rules.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0;
                m_last_core = 1'b1;
                m_cnt = 0;
                for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
                continue;
            end
            if (m_busy) begin
                m_busy = 1'b0;
                continue;
            end
            if (!bus.c_lock) m_cnt = 0;
            if (bus.h_req || bus.c_req) begin
                acc_t e;
                rd_t  r;
                e.abort = 1'b0;
                if (bus.h_req && bus.c_req) begin
                    if (bus.c_lock && m_cnt == LOCK_MAX) begin
                        e.core = 1'b0;
                        e.abort = 1'b1;
                    end else if (bus.c_lock && m_last_core) begin
                        e.core = 1'b1;
                    end else begin
                        e.core = !m_last_core;
                    end
                end else begin
                    e.core = bus.c_req;
                end
                e.cyc   = cyc + 1;
                e.we    = e.core ? bus.c_we : bus.h_we;
                e.addr  = e.core ? bus.c_addr : bus.h_addr;
                e.wdata = e.core ? bus.c_wdata : bus.h_wdata;
                m_last_core = e.core;
                if (!e.core) m_cnt = 0;
                else if (bus.c_lock) m_cnt = (m_cnt < LOCK_MAX) ? m_cnt + 1 : LOCK_MAX;
                if (e.we) begin
                    model_mem[e.addr[5:0]] = e.wdata;
                end else begin
                    r.cyc  = e.cyc + 1;
                    r.core = e.core;
                    r.data = model_mem[e.addr[5:0]];
                    rd_q.push_back(r);
                end
                exp_q.push_back(e);
                m_busy = 1'b1;
            end
        end
    end

    // Monitor: compares every access and every read return against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.read || bus.write || bus.h_gnt || bus.c_gnt || bus.lock_abort) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_access: got read=%b write=%b h_gnt=%b c_gnt=%b, expected no access",
                             bus.read, bus.write, bus.h_gnt, bus.c_gnt);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check_output("access",
                        192'({cyc, bus.h_gnt, bus.c_gnt, bus.read, bus.write, bus.lock_abort, bus.addr, bus.write_data}),
                        192'({e.cyc, !e.core, e.core, !e.we, e.we, e.abort, e.addr, e.wdata}));
                end
                if (bus.c_gnt) c_gnt_total++;
                if (bus.lock_abort) begin
                    abort_count++;
                    abort_at = c_gnt_total;
                end
            end
            if (bus.h_rvalid || bus.c_rvalid) begin
                if (rd_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_rvalid: got h_rvalid=%b c_rvalid=%b, expected none",
                             bus.h_rvalid, bus.c_rvalid);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check_output("read_return",
                        192'({cyc, bus.h_rvalid, bus.c_rvalid, bus.rdata}),
                        192'({r.cyc, !r.core, r.core, r.data}));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, a0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_lock = 0;
        repeat (3) @(negedge clk);
        check_output("rst_strobes", 192'({bus.read, bus.write, bus.h_gnt, bus.c_gnt}), 192'(0));
        check_output("rst_rvalid", 192'({bus.h_rvalid, bus.c_rvalid, bus.lock_abort}), 192'(0));
        check_output("rst_addr", 192'(bus.addr), 192'(0));
        check_output("rst_wdata", 192'(bus.write_data), 192'(0));
        check_output("rst_rdata", 192'(bus.rdata), 192'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] host write / read-back");
        apply_stimulus(0, 1, 16'd0, 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516, 0);
        apply_stimulus(0, 1, 16'd32, 128'hAAF43DDD_A22100EF_8766450A_B4321176, 0);
        apply_stimulus(0, 0, 16'd32, '0, 0);
        repeat (4) @(negedge clk);

        $display("[TB] continuous contention, no lock");
        fork
            for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 16'(i), '0, 0);
            for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 16'(i + 8), '0, 0);
        join
        repeat (4) @(negedge clk);

        $display("[TB] core read overtakes pending host write");
        apply_stimulus(0, 0, 16'd9, '0, 0);
        fork
            apply_stimulus(0, 1, 16'd12, {4{32'hC0FFEE01}}, 0);
            apply_stimulus(1, 0, 16'd5, '0, 0);
        join
        repeat (4) @(negedge clk);

        $display("[TB] core lock against waiting host");
        c0 = c_gnt_total;
        a0 = abort_count;
        fork
            for (int i = 0; i < 14; i++) apply_stimulus(1, 1, 16'(i), {4{32'(i) ^ 32'h5A5A0000}}, 1);
            apply_stimulus(0, 0, 16'd3, '0, 0);
        join
        check_output("lock_abort_count", 192'(abort_count - a0), 192'(1));
        check_output("lock_run_length", 192'(abort_at - c0), 192'(LOCK_MAX));
        repeat (4) @(negedge clk);

        $display("[TB] core lock alone");
        c0 = c_gnt_total;
        a0 = abort_count;
        for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 16'(i % 16), '0, 1);
        check_output("solo_lock_grants", 192'(c_gnt_total - c0), 192'(20));
        check_output("solo_lock_no_abort", 192'(abort_count - a0), 192'(0));
        repeat (4) @(negedge clk);

        $display("[TB] reset during a write access");
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 16'd40; bus.h_wdata = {4{32'hDEADBEEF}};
        @(posedge clk);
        #1;
        check_output("pre_rst_write", 192'({bus.write, bus.h_gnt}), 192'(2'b11));
        rst = 1'b1;
        #1;
        check_output("mid_rst_drop", 192'({bus.write, bus.read, bus.h_gnt, bus.c_gnt}), 192'(0));
        exp_q.delete();
        rd_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fork
            apply_stimulus(0, 1, 16'd40, {4{32'hDEADBEEF}}, 0);
            apply_stimulus(1, 1, 16'd41, {4{32'h0BADF00D}}, 0);
        join
        repeat (4) @(negedge clk);

        $display("[TB] randomized traffic");
        fork
            for (int i = 0; i < 50; i++) begin
                apply_stimulus(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                               {$urandom, $urandom, $urandom, $urandom}, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int i = 0; i < 50; i++) begin
                apply_stimulus(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) == 0));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        join
        repeat (10) @(negedge clk);

        check_output("access_queue_drained", 192'(exp_q.size()), 192'(0));
        check_output("read_queue_drained", 192'(rd_q.size()), 192'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
